// File: rtl/vec_dot_product_seq_ctrl_if.sv
// Handshake and data bundle for vec_dot_product_seq_ctrl.
// The master side is the job issuer / chunk producer / result consumer,
// the slave side is the sequencing controller itself.
interface vec_dot_product_seq_ctrl_if #(
  parameter int MAX_CHUNKS = 16,
  parameter int LEN_W      = $clog2(MAX_CHUNKS + 1),
  parameter int ACC_W      = 19 + $clog2(MAX_CHUNKS)
);
  logic             start;
  logic [LEN_W-1:0] cfg_len;
  logic             abort;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      vec_a;
  logic [63:0]      vec_b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] dot_product;

  modport master (
    output start, cfg_len, abort, in_valid, vec_a, vec_b, out_ready,
    input  busy, in_ready, out_valid, dot_product
  );

  modport slave (
    input  start, cfg_len, abort, in_valid, vec_a, vec_b, out_ready,
    output busy, in_ready, out_valid, dot_product
  );
endinterface

// File: rtl/vec_dot_product_seq_ctrl.sv
// Dot-product sequencing controller: streams 8-lane chunks through an
// 8x8 unsigned multiply / tree-add and accumulates the chunk sums over a
// programmed number of chunks, then offers the total on a valid/ready port.
// Optional macro DOT_CTRL_PIPE_EN registers the chunk sum before the
// accumulator and adds a one-cycle DRAIN state to absorb the last sum.
module vec_dot_product_seq_ctrl #(
  parameter int MAX_CHUNKS = 16,
  parameter int LEN_W      = $clog2(MAX_CHUNKS + 1),
  parameter int ACC_W      = 19 + $clog2(MAX_CHUNKS)
) (
  input logic                        clk,
  input logic                        rst,
  vec_dot_product_seq_ctrl_if.slave  io
);

  // DRAIN is only ever entered when the pipeline register is present
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_next;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] dot_q;
  logic [18:0]      chunk_sum;
  logic             beat;
  logic             last_beat;

`ifdef DOT_CTRL_PIPE_EN
  logic [18:0]      sum_q;
  logic             sum_vld;
  logic [ACC_W-1:0] acc_pipe;
  assign acc_pipe = acc + (sum_vld ? ACC_W'(sum_q) : '0);
`else
  logic [ACC_W-1:0] acc_sum;
  assign acc_sum = acc + ACC_W'(chunk_sum);
`endif

  assign last_beat      = (cnt == len - LEN_W'(1));
  assign io.busy        = (state != IDLE);
  assign io.in_ready    = (state == RUN);
  assign io.out_valid   = (state == DONE);
  assign io.dot_product = dot_q;

  // Sum of the eight lane products of the current chunk (max 8*255*255 fits 19 bits)
  always_comb begin
    chunk_sum = '0;
    for (int i = 0; i < 8; i++) begin
      chunk_sum = chunk_sum + 19'(16'(io.vec_a[i*8 +: 8]) * 16'(io.vec_b[i*8 +: 8]));
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; abort always beats a simultaneous final beat
  always_comb begin
    state_next = state;
    beat       = 1'b0;
    case (state)
      IDLE: begin
        if (io.start) state_next = (io.cfg_len == '0) ? DONE : RUN;
      end
      RUN: begin
        beat = io.in_valid;
        if (io.abort) begin
          state_next = IDLE;
        end else if (io.in_valid && last_beat) begin
`ifdef DOT_CTRL_PIPE_EN
          state_next = DRAIN;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef DOT_CTRL_PIPE_EN
      DRAIN: begin
        state_next = io.abort ? IDLE : DONE;
      end
`endif
      DONE: begin
        if (io.abort || io.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Job length, chunk counter, accumulator and registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      len   <= '0;
      dot_q <= '0;
`ifdef DOT_CTRL_PIPE_EN
      sum_q   <= '0;
      sum_vld <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (io.start) begin
            acc   <= '0;
            cnt   <= '0;
            dot_q <= '0;
            len   <= (io.cfg_len > LEN_W'(MAX_CHUNKS)) ? LEN_W'(MAX_CHUNKS) : io.cfg_len;
`ifdef DOT_CTRL_PIPE_EN
            sum_vld <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (io.abort) begin
            acc <= '0;
            cnt <= '0;
`ifdef DOT_CTRL_PIPE_EN
            sum_vld <= 1'b0;
`endif
          end else begin
`ifdef DOT_CTRL_PIPE_EN
            acc     <= acc_pipe;
            sum_vld <= beat;
            if (beat) begin
              sum_q <= chunk_sum;
              cnt   <= cnt + LEN_W'(1);
            end
`else
            if (beat) begin
              acc <= acc_sum;
              cnt <= cnt + LEN_W'(1);
              if (last_beat) dot_q <= acc_sum;
            end
`endif
          end
        end
`ifdef DOT_CTRL_PIPE_EN
        DRAIN: begin
          if (io.abort) begin
            acc <= '0;
          end else begin
            acc   <= acc_pipe;
            dot_q <= acc_pipe;
          end
          sum_vld <= 1'b0;
        end
`endif
        DONE: begin
          if (io.abort) acc <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_dot_product_seq_ctrl.sv
// Scoreboard bench for vec_dot_product_seq_ctrl: the driver issues jobs and
// pushes the reference result into a queue; a monitor pops on every result
// handshake. Honours DOT_CTRL_PIPE_EN for the expected latency.
module tb_vec_dot_product_seq_ctrl;
  localparam int MAX_CHUNKS = 16;
  localparam int LEN_W      = $clog2(MAX_CHUNKS + 1);
  localparam int ACC_W      = 19 + $clog2(MAX_CHUNKS);
`ifdef DOT_CTRL_PIPE_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 1;
`endif

  typedef struct {
    longint value;
    int     beats;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  exp_t        sb[$];
  logic [63:0] a_mem[32];
  logic [63:0] b_mem[32];
  int          n_checks = 0;
  int          n_fail = 0;
  int          beat_cnt = 0;

  vec_dot_product_seq_ctrl_if #(.MAX_CHUNKS(MAX_CHUNKS), .LEN_W(LEN_W), .ACC_W(ACC_W)) io ();

  vec_dot_product_seq_ctrl #(.MAX_CHUNKS(MAX_CHUNKS), .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: plain arithmetic over the first n stored chunks
  function automatic longint model(input int n);
    longint s = 0;
    for (int k = 0; k < n; k++)
      for (int i = 0; i < 8; i++)
        s += longint'(a_mem[k][i*8 +: 8]) * longint'(b_mem[k][i*8 +: 8]);
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_const(input logic [7:0] a, input logic [7:0] b);
    for (int k = 0; k < 32; k++) begin
      a_mem[k] = {8{a}};
      b_mem[k] = {8{b}};
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < 32; k++) begin
      a_mem[k] = {$urandom, $urandom};
      b_mem[k] = {$urandom, $urandom};
    end
  endtask

  // Full job: start, feed chunks with gaps, check latency, stall the result, accept it
  task automatic run_job(input int cfg, input int gap, input int stall);
    int   n;
    int   g;
    int   lat;
    exp_t e;
    check_val("idle_busy", io.busy, 0);
    n = (cfg > MAX_CHUNKS) ? MAX_CHUNKS : cfg;
    e.value = model(n);
    e.beats = n;
    sb.push_back(e);
    io.start   = 1'b1;
    io.cfg_len = LEN_W'(cfg);
    step();
    io.start = 1'b0;
    check_val("start_busy", io.busy, 1);
    for (int k = 0; k < n; k++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) begin
        io.in_valid = 1'b0;
        check_val("stall_in_ready", io.in_ready, 1);
        step();
      end
      io.in_valid = 1'b1;
      io.vec_a    = a_mem[k];
      io.vec_b    = b_mem[k];
      check_val("run_in_ready", io.in_ready, 1);
      step();
    end
    io.in_valid = 1'b0;
    io.vec_a    = {$urandom, $urandom};
    io.vec_b    = {$urandom, $urandom};
    lat = 1;
    while (io.out_valid !== 1'b1 && lat < 8) begin
      check_val("drain_in_ready", io.in_ready, 0);
      step();
      lat++;
    end
    check_val("latency", lat, (n == 0) ? 1 : EXP_LAT);
    check_val("done_in_ready", io.in_ready, 0);
    repeat (stall) begin
      io.out_ready = 1'b0;
      io.start     = 1'b1;
      io.cfg_len   = LEN_W'(1);
      check_val("stall_out_valid", io.out_valid, 1);
      check_val("stall_result", io.dot_product, e.value);
      step();
    end
    io.start     = 1'b0;
    io.out_ready = 1'b1;
    check_val("done_result", io.dot_product, e.value);
    step();
    io.out_ready = 1'b0;
    check_val("post_out_valid", io.out_valid, 0);
    check_val("post_busy", io.busy, 0);
  endtask

  // Job cut short by abort after some beats; optionally the abort coincides with a beat
  task automatic run_abort(input int cfg, input int beats_before, input bit beat_with_abort);
    io.start   = 1'b1;
    io.cfg_len = LEN_W'(cfg);
    step();
    io.start = 1'b0;
    for (int k = 0; k < beats_before; k++) begin
      io.in_valid = 1'b1;
      io.vec_a    = a_mem[k];
      io.vec_b    = b_mem[k];
      step();
    end
    io.abort    = 1'b1;
    io.in_valid = beat_with_abort;
    step();
    io.abort    = 1'b0;
    io.in_valid = 1'b0;
    beat_cnt    = 0;
    check_val("abort_busy", io.busy, 0);
    check_val("abort_in_ready", io.in_ready, 0);
    repeat (3) begin
      check_val("abort_out_valid", io.out_valid, 0);
      step();
    end
  endtask

  // Monitor: count accepted beats and score every result handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        beat_cnt = 0;
      end else begin
        if (io.in_valid && io.in_ready) beat_cnt++;
        if (io.out_valid && io.out_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_result: got %0d, expected no result", io.dot_product);
          end else begin
            e = sb.pop_front();
            check_val("sb_result", io.dot_product, e.value);
            check_val("sb_beats", beat_cnt, e.beats);
          end
          beat_cnt = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst          = 1'b1;
    io.start     = 1'b0;
    io.cfg_len   = '0;
    io.abort     = 1'b0;
    io.in_valid  = 1'b0;
    io.vec_a     = '0;
    io.vec_b     = '0;
    io.out_ready = 1'b0;
    step();
    step();
    check_val("reset_busy", io.busy, 0);
    check_val("reset_in_ready", io.in_ready, 0);
    check_val("reset_out_valid", io.out_valid, 0);
    check_val("reset_dot", io.dot_product, 0);
    rst = 1'b0;
    step();

    $display("[TB] len=1 all lanes 0xFF");
    fill_const(8'hFF, 8'hFF);
    run_job(1, 0, 0);

    $display("[TB] len=2 with idle gaps");
    for (int i = 0; i < 8; i++) begin
      a_mem[0][i*8 +: 8] = 8'(i + 1);
      b_mem[0][i*8 +: 8] = 8'd1;
      a_mem[1][i*8 +: 8] = 8'd2;
      b_mem[1][i*8 +: 8] = 8'd3;
    end
    run_job(2, 3, 0);

    $display("[TB] len=16 all 0xFF with result back-pressure");
    fill_const(8'hFF, 8'hFF);
    run_job(16, 0, 5);

    $display("[TB] zero and oversized lengths");
    fill_random();
    run_job(0, 0, 1);
    run_job(20, 0, 0);

    $display("[TB] abort after 2 of 4, then fresh len=1 job");
    fill_random();
    run_abort(4, 2, 1'b0);
    fill_const(8'd1, 8'd1);
    run_job(1, 0, 0);

    $display("[TB] abort coinciding with final beat");
    fill_random();
    run_abort(2, 1, 1'b1);

    $display("[TB] reset mid-job");
    io.start   = 1'b1;
    io.cfg_len = LEN_W'(8);
    step();
    io.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      io.in_valid = 1'b1;
      io.vec_a    = a_mem[k];
      io.vec_b    = b_mem[k];
      step();
    end
    io.in_valid = 1'b0;
    rst = 1'b1;
    step();
    check_val("midrst_busy", io.busy, 0);
    check_val("midrst_in_ready", io.in_ready, 0);
    check_val("midrst_out_valid", io.out_valid, 0);
    check_val("midrst_dot", io.dot_product, 0);
    rst      = 1'b0;
    beat_cnt = 0;
    step();
    fill_random();
    run_job(1, 0, 0);

    $display("[TB] randomized jobs");
    for (int j = 0; j < 10; j++) begin
      fill_random();
      run_job(int'($urandom_range(0, 20)), -1, int'($urandom_range(0, 3)));
    end

    for (int w = 0; w < 10 && sb.size() != 0; w++) step();
    check_val("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vec_dot_product_seq_ctrl.md
Name: vec_dot_product_seq_ctrl

Overview:
Sequencing controller that computes a dot product over vectors longer than 8 elements by streaming 8-lane chunks through an internal 8-lane unsigned 8x8 multiply / tree-add datapath (19-bit chunk sum). It accumulates the chunk sums across a programmed number of chunks and presents the final result on a valid/ready output. It sits between a chunk producer (memory reader or FIFO) and a result consumer.

Parameters:
MAX_CHUNKS, 16, maximum chunks per job (>=1).
LEN_W, $clog2(MAX_CHUNKS+1), width of cfg_len.
ACC_W, 19+$clog2(MAX_CHUNKS), accumulator/result width; guarantees no overflow.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  job start pulse; sampled only in IDLE.
cfg_len  in  LEN_W  chunk count for the job; sampled with start.
abort  in  1  cancels the current job; ignored in IDLE.
busy  out  1  high in every state except IDLE.
in_valid  in  1  chunk valid.
in_ready  out  1  controller accepts a chunk.
vec_a  in  64  chunk operand A, lane i = [i*8 +: 8], unsigned.
vec_b  in  64  chunk operand B, same lane layout.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
dot_product  out  ACC_W  accumulated result.

Behaviour:
- One clock. Reset is synchronous and active-high. rst forces IDLE. busy, in_ready, out_valid, dot_product, the accumulator and the chunk counter all reset to 0. rst has priority over every other input and aborts a job mid-flight.
- States: IDLE, RUN, DRAIN (only with the optional feature), DONE.
- IDLE: in_ready=0, out_valid=0.
  - On start with cfg_len>=1: latch len=min(cfg_len, MAX_CHUNKS), clear acc and cnt, go to RUN.
  - On start with cfg_len==0: clear acc, go to DONE (result 0).
- RUN: in_ready=1.
  - On a beat (in_valid & in_ready): acc += sum over i=0..7 of vec_a[i]*vec_b[i] (zero-extended to ACC_W); cnt++.
  - When a beat is accepted with cnt==len-1: go to DONE (or DRAIN when the feature is enabled); in_ready drops the next cycle.
  - in_valid low stalls the job with no state change.
- DONE: out_valid=1; dot_product=acc, held stable while out_ready=0. On out_valid & out_ready go to IDLE next cycle, with out_valid=0.
- dot_product is registered. It holds its last value in IDLE and is cleared only by rst or a new start.
- abort in RUN or DRAIN: go to IDLE next cycle, discard acc, in_ready=0. abort in DONE: drop the result, go to IDLE.
  - abort in the same cycle as the final beat: the abort wins and the beat is consumed but discarded.
- start and cfg_len are ignored when busy=1.
- Latency: final beat accepted at cycle T gives out_valid=1 at T+1.
- Throughput: one chunk per cycle.
- Job turnaround: DONE->IDLE takes 1 cycle, so back-to-back jobs have a 1-cycle gap before start is honoured.

Optional Feature:
DOT_CTRL_PIPE_EN
- Defined:
  - A register stage is inserted between the 19-bit chunk sum and the accumulator.
  - A DRAIN state (in_ready=0, 1 cycle) absorbs the in-flight sum.
  - Final beat at T gives out_valid at T+2.
  - abort during DRAIN discards the in-flight sum.
- Undefined: the chunk sum feeds the accumulator combinationally, there is no DRAIN state, and latency is T+1. The results are identical either way.

Test Plan:
- len=1, all lanes a=b=0xFF, in_valid held -> one beat accepted; out_valid at T+1 (T+2 with DOT_CTRL_PIPE_EN); dot_product=520200 (0x7F008).
- len=2, chunk0 a lanes=1..8 with b=1, chunk1 a=2 with b=3, 3 idle cycles of in_valid=0 between chunks -> dot_product=84; in_ready=1 throughout RUN; exactly 2 beats accepted.
- len=16, all lanes 0xFF -> dot_product=8323200 (fits in 23 bits); then out_ready=0 for 5 cycles -> out_valid and dot_product stable, start pulses ignored; out_ready=1 -> IDLE next cycle.
- cfg_len=0 with start -> DONE next cycle, dot_product=0, no beats accepted; cfg_len=20 (MAX_CHUNKS=16) -> exactly 16 beats accepted.
- len=4, abort after 2 beats -> IDLE next cycle, out_valid never asserts; a new job with len=1, a=b=1 -> dot_product=8 (no stale accumulation).
- rst asserted mid-RUN after 3 of 8 beats -> all outputs 0 next cycle, busy=0; a following len=1 job computes correctly.
